// File: rtl/sync_bus_target.sv
// sync_bus_target: bus slave with DEPTH registers at BASE_ADDR and a
// programmable number of wait states before a one-cycle ack.
// Build option: define SYNC_BUS_TRISTATE_EN to float rdata_o (all Z) when
// not driving. Without it, rdata_o is all 0 when not driving, for an
// OR-combined data bus.
module sync_bus_target #(
    parameter int unsigned       ADDR_W      = 8,
    parameter int unsigned       DATA_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'hF0,
    parameter int unsigned       DEPTH       = 4,
    parameter int unsigned       WAIT_STATES = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              ack_o,
    output logic              hit_o
);

    localparam int unsigned IDX_W    = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         we_q, we_d;
    logic [DATA_W-1:0]            wdata_q, wdata_d;
    logic [DEPTH-1:0][DATA_W-1:0] regs_q;

    // BASE_ADDR is DEPTH-aligned, so a window match is just an upper-bit compare
    assign hit_o = (addr_i[ADDR_W-1:IDX_W] == BASE_ADDR[ADDR_W-1:IDX_W]);

    // Next-state logic: latch the request in IDLE, count wait states, abort on req drop
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_i && hit_o) begin
                    idx_d   = addr_i[IDX_W-1:0];
                    we_d    = we_i;
                    wdata_d = wdata_i;
                    if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_ACK;
                    end
                end
            end
            S_WAIT: begin
                if (!req_i) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) state_d = S_ACK;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // FSM and transaction latch registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // Register file: a write commits only on the edge leaving ACK
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            regs_q <= '0;
        end else if (state_q == S_ACK && we_q) begin
            regs_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o = (state_q == S_ACK);

    // Read data appears only in the ACK cycle of a read
`ifdef SYNC_BUS_TRISTATE_EN
    assign rdata_o = (state_q == S_ACK && !we_q) ? regs_q[idx_q] : {DATA_W{1'bz}};
`else
    assign rdata_o = (state_q == S_ACK && !we_q) ? regs_q[idx_q] : {DATA_W{1'b0}};
`endif

endmodule
